dac_sample_feeder: RTL and testbench



---
 rtl/dac_feed_pkg.sv | 32 +++
 rtl/dac_wave_shaper.sv | 45 ++++
 rtl/dac_sample_feeder.sv | 173 +++++++++++++++++
 tb/tb_dac_sample_feeder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_feed_pkg.sv
// -----------------------------------------------------------------------------
// dac_feed_pkg
// Shared widths, waveform codes and FSM state type for dac_sample_feeder.
//   DAC_W  : width of one DAC word
//   AMP_W  : width of the amplitude control (gain = (amp+1)/256)
//   wave_e : waveform select codes (saw, square, triangle, midscale DC)
//   state_e: generator FSM states
//   to_twos: offset-binary to two's-complement conversion
// -----------------------------------------------------------------------------
package dac_feed_pkg;

    localparam int unsigned DAC_W = 16;
    localparam int unsigned AMP_W = 8;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'b00,
        WAVE_SQR = 2'b01,
        WAVE_TRI = 2'b10,
        WAVE_DC  = 2'b11
    } wave_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Flipping the MSB maps offset-binary midscale (8000) onto two's-complement zero.
    function automatic logic [DAC_W-1:0] to_twos(input logic [DAC_W-1:0] x);
        return {~x[DAC_W-1], x[DAC_W-2:0]};
    endfunction

endpackage

// File: rtl/dac_wave_shaper.sv
// -----------------------------------------------------------------------------
// dac_wave_shaper
// Combinational waveform shaping and amplitude scaling for one sample.
// Ports:
//   i_phase_top : top 16 bits of the phase accumulator
//   i_wave      : waveform select
//   i_amp       : amplitude, gain = (amp+1)/256 (amp=FF is identity)
//   o_scaled    : scaled unsigned 16-bit sample (offset-binary)
// -----------------------------------------------------------------------------
module dac_wave_shaper
    import dac_feed_pkg::*;
(
    input  logic [DAC_W-1:0] i_phase_top,
    input  wave_e            i_wave,
    input  logic [AMP_W-1:0] i_amp,
    output logic [DAC_W-1:0] o_scaled
);

    logic [DAC_W-2:0]     w_tri;
    logic [DAC_W-1:0]     w_raw;
    logic [AMP_W:0]       w_gain;
    logic [DAC_W+AMP_W:0] w_product;
    logic                 w_unused_ovf;
    logic [AMP_W-1:0]     w_unused_frac;

    always_comb begin
        // Triangle ramps on the bits below the MSB; the MSB selects rise or fall.
        w_tri = i_phase_top[DAC_W-2:0];
        w_raw = 16'h8000;
        case (i_wave)
            WAVE_SAW: w_raw = i_phase_top;
            WAVE_SQR: w_raw = i_phase_top[DAC_W-1] ? 16'hFFFF : 16'h0000;
            WAVE_TRI: w_raw = i_phase_top[DAC_W-1] ? {~w_tri, 1'b0} : {w_tri, 1'b0};
            WAVE_DC:  w_raw = 16'h8000;
            default:  w_raw = 16'h8000;
        endcase
    end

    assign w_gain    = {1'b0, i_amp} + 9'd1;
    assign w_product = {{(AMP_W+1){1'b0}}, w_raw} * {{DAC_W{1'b0}}, w_gain};

    // Truncating divide by 256; bit 24 can never be set since raw*256 < 2^24.
    assign {w_unused_ovf, o_scaled, w_unused_frac} = w_product;

endmodule

// File: rtl/dac_sample_feeder.sv
// -----------------------------------------------------------------------------
// dac_sample_feeder
// NCO waveform generator feeding dac_interface.load: one 16-bit sample per DAC
// frame, updated only at frame boundaries, with a shadowed valid/ready config.
// Build option: define DAC_FEED_TWOS_COMP_EN to emit two's-complement samples
// (IDLE_CODE is always emitted unconverted).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   enable         : run generator; low returns to IDLE
//   cfg_valid/ready: config handshake (ready = no config pending)
//   cfg_wave       : 00 saw, 01 square, 10 triangle, 11 midscale DC
//   cfg_freq       : phase increment per sample
//   cfg_amp        : amplitude, gain = (amp+1)/256
//   load_word      : registered sample to dac_interface.load
//   sample_strobe  : one-cycle pulse in the cycle load_word updates
// -----------------------------------------------------------------------------
module dac_sample_feeder
    import dac_feed_pkg::*;
#(
    parameter int unsigned PHASE_W      = 24,
    parameter int unsigned FRAME_CYCLES = 18,
    parameter logic [15:0] IDLE_CODE    = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_wave,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [7:0]         cfg_amp,
    output logic [15:0]        load_word,
    output logic               sample_strobe
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_frame_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [DAC_W-1:0]   r_load;
    logic [DAC_W-1:0]   w_load_nxt;
    logic               r_strobe;
    logic               w_strobe_nxt;

    wave_e              r_act_wave;
    logic [PHASE_W-1:0] r_act_freq;
    logic [AMP_W-1:0]   r_act_amp;
    wave_e              r_sh_wave;
    logic [PHASE_W-1:0] r_sh_freq;
    logic [AMP_W-1:0]   r_sh_amp;
    logic               r_cfg_pending;

    logic               w_boundary;
    logic               w_accept;
    logic               w_apply;
    logic [DAC_W-1:0]   w_scaled;
    logic [DAC_W-1:0]   w_converted;

    assign cfg_ready     = !r_cfg_pending;
    assign load_word     = r_load;
    assign sample_strobe = r_strobe;

    assign w_boundary = (r_frame_cnt == LAST_CNT);
    assign w_accept   = cfg_valid && !r_cfg_pending;

    dac_wave_shaper u_shaper (
        .i_phase_top (r_phase[PHASE_W-1 -: DAC_W]),
        .i_wave      (r_act_wave),
        .i_amp       (r_act_amp),
        .o_scaled    (w_scaled)
    );

`ifdef DAC_FEED_TWOS_COMP_EN
    assign w_converted = to_twos(w_scaled);
`else
    assign w_converted = w_scaled;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values. The boundary sample and phase step
    // use the active config as it stood before this edge; the shadow copy
    // (w_apply) lands in the same edge and is first seen at the next strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_nxt  = r_frame_cnt;
        w_phase_nxt  = r_phase;
        w_load_nxt   = r_load;
        w_strobe_nxt = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_frame_nxt = '0;
                w_phase_nxt = '0;
                w_load_nxt  = IDLE_CODE;
                w_apply     = r_cfg_pending;
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Partial frame is dropped without a strobe.
                    w_state_nxt = ST_IDLE;
                    w_frame_nxt = '0;
                    w_phase_nxt = '0;
                    w_load_nxt  = IDLE_CODE;
                end else if (w_boundary) begin
                    w_frame_nxt  = '0;
                    w_load_nxt   = w_converted;
                    w_phase_nxt  = r_phase + r_act_freq;
                    w_strobe_nxt = 1'b1;
                    w_apply      = r_cfg_pending;
                end else begin
                    w_frame_nxt = r_frame_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_phase     <= '0;
            r_load      <= IDLE_CODE;
            r_strobe    <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_nxt;
            r_phase     <= w_phase_nxt;
            r_load      <= w_load_nxt;
            r_strobe    <= w_strobe_nxt;
        end
    end

    // Accept and apply are mutually exclusive: accept needs pending=0,
    // apply needs pending=1, so an offer on a boundary edge waits a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_wave    <= WAVE_SAW;
            r_act_freq    <= '0;
            r_act_amp     <= '1;
            r_sh_wave     <= WAVE_SAW;
            r_sh_freq     <= '0;
            r_sh_amp      <= '0;
            r_cfg_pending <= 1'b0;
        end else if (w_apply) begin
            r_act_wave    <= r_sh_wave;
            r_act_freq    <= r_sh_freq;
            r_act_amp     <= r_sh_amp;
            r_cfg_pending <= 1'b0;
        end else if (w_accept) begin
            r_sh_wave     <= wave_e'(cfg_wave);
            r_sh_freq     <= cfg_freq;
            r_sh_amp      <= cfg_amp;
            r_cfg_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
module tb_dac_sample_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_wave;
    logic [23:0] cfg_freq;
    logic [7:0]  cfg_amp;
    logic [15:0] load_word;
    logic        sample_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dac_sample_feeder #(
        .PHASE_W      (24),
        .FRAME_CYCLES (18),
        .IDLE_CODE    (16'h0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_wave      (cfg_wave),
        .cfg_freq      (cfg_freq),
        .cfg_amp       (cfg_amp),
        .load_word     (load_word),
        .sample_strobe (sample_strobe)
    );

    function automatic logic [15:0] conv(input logic [15:0] x);
`ifdef DAC_FEED_TWOS_COMP_EN
        return {~x[15], x[14:0]};
`else
        return x;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until the next strobe (bounded) and checks gap and value.
    task automatic next_strobe(input string tag, input logic [15:0] exp_word, input int exp_gap);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_strobe && n < 40);
        check_eq({tag, "_gap"}, n, exp_gap);
        check_eq({tag, "_word"}, load_word, exp_word);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg_idle(input logic [1:0] w, input logic [23:0] f, input logic [7:0] a);
        cfg_wave  = w;
        cfg_freq  = f;
        cfg_amp   = a;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_eq("cfg_busy_idle", cfg_ready, 1'b0);
        tick();
        check_eq("cfg_ready_idle", cfg_ready, 1'b1);
    endtask

    logic [15:0] tri_exp [4];
    logic        saw_strobe;

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_wave  = 2'b00;
        cfg_freq  = '0;
        cfg_amp   = '0;
        tri_exp[0] = 16'h0000;
        tri_exp[1] = 16'h8000;
        tri_exp[2] = 16'hFFFE;
        tri_exp[3] = 16'h7FFE;

        // Reset state
        tick();
        tick();
        check_eq("rst_load", load_word, 16'h0000);
        check_eq("rst_strobe", sample_strobe, 1'b0);
        check_eq("rst_ready", cfg_ready, 1'b1);
        reset = 1'b0;

        // Saw ramp, amp FF
        cfg_idle(2'b00, 24'h100000, 8'hFF);
        enable = 1'b1;
        tick();
        check_eq("run_entry_load", load_word, 16'h0000);
        next_strobe("saw0", conv(16'h0000), 18);
        for (int i = 1; i <= 16; i++) begin
            next_strobe("saw", conv(16'((i % 16) << 12)), 18);
        end

        // Drop enable mid-frame
        repeat (9) tick();
        enable = 1'b0;
        tick();
        check_eq("drop_load", load_word, 16'h0000);
        check_eq("drop_strobe", sample_strobe, 1'b0);
        saw_strobe = 1'b0;
        repeat (20) begin
            tick();
            saw_strobe = saw_strobe | sample_strobe;
        end
        check_eq("idle_no_strobe", saw_strobe, 1'b0);
        enable = 1'b1;
        tick();
        next_strobe("reenable", conv(16'h0000), 18);

        // Config offered mid-frame while running saw
        repeat (5) tick();
        cfg_wave  = 2'b11;
        cfg_freq  = 24'h100000;
        cfg_amp   = 8'hFF;
        cfg_valid = 1'b1;
        tick();
        check_eq("cfg_busy_run", cfg_ready, 1'b0);
        // A different offer held while busy must be ignored.
        cfg_wave = 2'b01;
        cfg_amp  = 8'h7F;
        repeat (10) tick();
        check_eq("cfg_busy_hold", cfg_ready, 1'b0);
        tick();
        cfg_valid = 1'b0;
        check_eq("cfg_busy_last", cfg_ready, 1'b0);
        tick();
        check_eq("bnd_strobe", sample_strobe, 1'b1);
        check_eq("bnd_old_cfg", load_word, conv(16'h1000));
        check_eq("bnd_ready", cfg_ready, 1'b1);
        next_strobe("dc", conv(16'h8000), 18);

        // Reset mid-frame with a config pending
        repeat (11) tick();
        cfg_wave  = 2'b11;
        cfg_freq  = 24'h800000;
        cfg_amp   = 8'hFF;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_eq("pend_before_rst", cfg_ready, 1'b0);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check_eq("mid_rst_load", load_word, 16'h0000);
        check_eq("mid_rst_strobe", sample_strobe, 1'b0);
        check_eq("mid_rst_ready", cfg_ready, 1'b1);
        reset = 1'b0;
        tick();
        check_eq("post_rst_ready", cfg_ready, 1'b1);
        enable = 1'b1;
        tick();
        next_strobe("post_rst0", conv(16'h0000), 18);
        next_strobe("post_rst1", conv(16'h0000), 18);

        // Square, amp 7F
        do_reset();
        cfg_idle(2'b01, 24'h400000, 8'h7F);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            next_strobe("sqr", conv(((i % 4) >= 2) ? 16'h7FFF : 16'h0000), 18);
        end

        // Triangle, amp FF
        do_reset();
        cfg_idle(2'b10, 24'h400000, 8'hFF);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            next_strobe("tri", conv(tri_exp[i % 4]), 18);
        end

        // Offer accepted on the boundary edge applies one boundary later
        repeat (17) tick();
        cfg_wave  = 2'b10;
        cfg_freq  = 24'h400000;
        cfg_amp   = 8'h7F;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_eq("bacc_strobe", sample_strobe, 1'b1);
        check_eq("bacc_word", load_word, conv(16'h0000));
        check_eq("bacc_pending", cfg_ready, 1'b0);
        next_strobe("bacc_old", conv(16'h8000), 18);
        check_eq("bacc_ready", cfg_ready, 1'b1);
        next_strobe("bacc_new", conv(16'h7FFF), 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
